if_id_buf: RTL

- Two-entry elastic pipeline buffer between instruction fetch and decode.
- Captures {pc, inst} pairs from inst_fetch and presents them to the decode stage through a valid/ready handshake.
- Absorbs a one-cycle decode stall without losing an instruction; the skid entry lets fetch-side ready be fully registered.
- Supports synchronous flush for branch redirect.

---
 rtl/if_id_pkg.sv | 32 +++
 rtl/if_id_buf.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/if_id_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_pkg
// Description : Shared types and constants for the IF/ID elastic buffer.
//               Occupancy encoding, the NOP pattern used for empty entries,
//               and small helpers that decode the occupancy state.
// Revision    : 1.0 - initial release
// ============================================================================
package if_id_pkg;

    // Buffer occupancy: nothing held, main entry only, main plus skid entry
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } ifid_state_t;

    // MIPS NOP (sll $0,$0,0); an empty slot always presents this word
    localparam logic [31:0] INST_NOP = 32'h0000_0000;

    // Decode stage sees a valid instruction whenever anything is held
    function automatic logic state_has_data(input ifid_state_t s);
        return (s != EMPTY);
    endfunction

    // Fetch may push whenever the skid slot is still free
    function automatic logic state_can_accept(input ifid_state_t s);
        return (s != FULL);
    endfunction

endpackage : if_id_pkg
`default_nettype wire

// File: rtl/if_id_buf.sv
`default_nettype none
// ============================================================================
// Module      : if_id_buf
// Description : Two-entry elastic buffer between instruction fetch and
//               decode. A main entry drives decode directly from flops and a
//               skid entry absorbs one extra instruction while decode stalls,
//               so the fetch-side ready is purely registered. A synchronous
//               flush discards everything for a branch redirect.
//               Optional build macro IFID_STALL_CNT_EN adds a saturating
//               16-bit counter of decode-stall cycles on port o_stall_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_buf
    import if_id_pkg::*;
#(
    parameter int NPC   = 6,
    parameter int NINST = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic [NPC-1:0]   i_pc,
    input  logic [NINST-1:0] i_inst,
    output logic             o_ready,
    output logic             o_valid,
    output logic [NPC-1:0]   o_pc,
    output logic [NINST-1:0] o_inst,
    input  logic             i_ready
`ifdef IFID_STALL_CNT_EN
    ,
    output logic [15:0]      o_stall_cnt
`endif
);

    // One buffered fetch result
    typedef struct packed {
        logic [NPC-1:0]   pc;
        logic [NINST-1:0] inst;
    } entry_t;

    // Value of an unoccupied slot: PC 0 with a NOP, never X
    localparam entry_t C_ENTRY_CLR = '{pc: '0, inst: NINST'(INST_NOP)};

    ifid_state_t r_state;
    entry_t      r_main;
    entry_t      r_skid;
    logic        r_ready;
    logic        r_valid;

    ifid_state_t w_state_nxt;
    entry_t      w_main_nxt;
    entry_t      w_skid_nxt;
    entry_t      w_in;
    logic        w_push;
    logic        w_pop;

    assign w_in   = {i_pc, i_inst};
    assign w_push = i_valid & r_ready;
    assign w_pop  = r_valid & i_ready;

    // Next occupancy and entry contents; flush wins over any handshake
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (i_flush) begin
            w_state_nxt = EMPTY;
            w_main_nxt  = C_ENTRY_CLR;
            w_skid_nxt  = C_ENTRY_CLR;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        w_state_nxt = ONE;
                        w_main_nxt  = w_in;
                    end
                end
                ONE: begin
                    if (w_push && !w_pop) begin
                        // decode stalled: the younger instruction parks in skid
                        w_state_nxt = FULL;
                        w_skid_nxt  = w_in;
                    end else if (w_push && w_pop) begin
                        w_main_nxt  = w_in;
                    end else if (w_pop) begin
                        w_state_nxt = EMPTY;
                        w_main_nxt  = C_ENTRY_CLR;
                    end
                end
                FULL: begin
                    // ready is low here, so only a pop can move the state
                    if (w_pop) begin
                        w_state_nxt = ONE;
                        w_main_nxt  = r_skid;
                        w_skid_nxt  = C_ENTRY_CLR;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                    w_main_nxt  = C_ENTRY_CLR;
                    w_skid_nxt  = C_ENTRY_CLR;
                end
            endcase
        end
    end

    // State, entries and handshake flags; flags track the next state so they
    // always equal the decode of the registered occupancy
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= EMPTY;
            r_main  <= C_ENTRY_CLR;
            r_skid  <= C_ENTRY_CLR;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
            r_ready <= state_can_accept(w_state_nxt);
            r_valid <= state_has_data(w_state_nxt);
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_pc    = r_main.pc;
    assign o_inst  = r_main.inst;

`ifdef IFID_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Count cycles where decode holds off a valid instruction; saturates and
    // is deliberately left untouched by flush
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= 16'd0;
        end else if (r_valid && !i_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule : if_id_buf
`default_nettype wire
